fwd_result_pipe: RTL and testbench

// - Producer side of operand forwarding for the 6-stage core (F D E M W U).
// - Carries rd / RegWrite / result of each retiring instruction through the
//   M, W and U stages, and drives rdM/rdW/rdU and RegWriteM/W/U to the

---
 rtl/fwd_result_pipe_pkg.sv | 40 ++++
 rtl/fwd_result_pipe_if.sv | 43 ++++
 rtl/fwd_result_pipe_wb_stage_reg.sv | 27 ++
 rtl/fwd_result_pipe.sv | 84 ++++++++
 tb/tb_fwd_result_pipe.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_result_pipe_pkg.sv
// Shared core definitions for the result pipeline: widths, forwarding select
// codes, the per-stage writeback record and the operand forwarding mux.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10,
    FWD_U  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
    logic [XLEN-1:0]    data;
  } stage_wb_t;

  // Selects one E-stage operand source; every code is a legal source.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] m_val,
    input logic [XLEN-1:0] w_val,
    input logic [XLEN-1:0] u_val
  );
    logic [XLEN-1:0] val;
    case (fwd_sel_e'(sel))
      FWD_RF: val = rf_val;
      FWD_M:  val = m_val;
      FWD_W:  val = w_val;
      FWD_U:  val = u_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/fwd_result_pipe_if.sv
// Bus between the E-stage datapath / forwarding unit and the result pipeline.
// master drives the E-stage inputs; slave is the pipeline itself.
interface fwd_result_pipe_if;
  import core_pkg::*;

  logic               hold_i;
  logic               flush_i;
  logic [RADDR_W-1:0] rdE;
  logic               RegWriteE;
  logic               is_loadE;
  logic [XLEN-1:0]    alu_resultE;
  logic [XLEN-1:0]    mem_rdataW;
  logic [XLEN-1:0]    rs1_rf;
  logic [XLEN-1:0]    rs2_rf;
  logic [1:0]         fwd_path_A;
  logic [1:0]         fwd_path_B;

  logic [RADDR_W-1:0] rdM;
  logic [RADDR_W-1:0] rdW;
  logic [RADDR_W-1:0] rdU;
  logic               RegWriteM;
  logic               RegWriteW;
  logic               RegWriteU;
  logic [XLEN-1:0]    resultW;
  logic [XLEN-1:0]    operand_A;
  logic [XLEN-1:0]    operand_B;
  logic               load_use_stall;

  modport master (
    output hold_i, flush_i, rdE, RegWriteE, is_loadE, alu_resultE,
           mem_rdataW, rs1_rf, rs2_rf, fwd_path_A, fwd_path_B,
    input  rdM, rdW, rdU, RegWriteM, RegWriteW, RegWriteU,
           resultW, operand_A, operand_B, load_use_stall
  );

  modport slave (
    input  hold_i, flush_i, rdE, RegWriteE, is_loadE, alu_resultE,
           mem_rdataW, rs1_rf, rs2_rf, fwd_path_A, fwd_path_B,
    output rdM, rdW, rdU, RegWriteM, RegWriteW, RegWriteU,
           resultW, operand_A, operand_B, load_use_stall
  );

endinterface

// File: rtl/fwd_result_pipe_wb_stage_reg.sv
// One writeback-tracking pipeline register. Priority: rst > hold > bubble > load.
module wb_stage_reg
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  stage_wb_t d,
  output stage_wb_t q
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (bubble) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/fwd_result_pipe.sv
// Producer side of operand forwarding: tracks rd/RegWrite/result through M, W
// and U, muxes the E-stage operands and raises the load-use bubble.
module fwd_result_pipe
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fwd_result_pipe_if.slave bus
);

  stage_wb_t       m_d;
  stage_wb_t       m_q;
  stage_wb_t       w_q;
  stage_wb_t       u_d;
  stage_wb_t       u_q;
  logic [XLEN-1:0] result_w;
  logic            load_use;
  logic            bubble_m;
  logic            unused_u_is_load;

  assign m_d = '{rd:       bus.rdE,
                 regwrite: bus.RegWriteE,
                 is_load:  bus.is_loadE,
                 data:     bus.alu_resultE};

  // Load data only exists from W onward, so U captures the resolved result.
  assign result_w = w_q.is_load ? bus.mem_rdataW : w_q.data;

  assign u_d = '{rd:       w_q.rd,
                 regwrite: w_q.regwrite,
                 is_load:  w_q.is_load,
                 data:     result_w};

  // A load sitting in M has no data yet; a consumer selecting M must wait.
  assign load_use = m_q.is_load && m_q.regwrite && (m_q.rd != '0) &&
                    ((bus.fwd_path_A == FWD_M) || (bus.fwd_path_B == FWD_M));

  assign bubble_m = bus.flush_i || load_use;

  wb_stage_reg u_stage_m (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold_i),
    .bubble (bubble_m),
    .d      (m_d),
    .q      (m_q)
  );

  wb_stage_reg u_stage_w (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold_i),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  wb_stage_reg u_stage_u (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold_i),
    .bubble (1'b0),
    .d      (u_d),
    .q      (u_q)
  );

  assign unused_u_is_load = u_q.is_load;

  assign bus.rdM            = m_q.rd;
  assign bus.rdW            = w_q.rd;
  assign bus.rdU            = u_q.rd;
  assign bus.RegWriteM      = m_q.regwrite;
  assign bus.RegWriteW      = w_q.regwrite;
  assign bus.RegWriteU      = u_q.regwrite;
  assign bus.resultW        = result_w;
  assign bus.load_use_stall = load_use;

  // M forwards its ALU value; a load there is covered by the stall above.
  assign bus.operand_A = fwd_mux(bus.fwd_path_A, bus.rs1_rf, m_q.data,
                                 result_w, u_q.data);
  assign bus.operand_B = fwd_mux(bus.fwd_path_B, bus.rs2_rf, m_q.data,
                                 result_w, u_q.data);

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed self-checking bench for fwd_result_pipe: hand-sequenced pipeline
// scenarios plus a table of operand-mux vectors applied while frozen.
module tb_fwd_result_pipe;
  import core_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fwd_result_pipe_if bus ();

  fwd_result_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  path_a;
    logic [1:0]  path_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_stall;
  } mux_vec_t;

  mux_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [31:0] alu);
    bus.rdE         = rd;
    bus.RegWriteE   = we;
    bus.is_loadE    = ld;
    bus.alu_resultE = alu;
  endtask

  task automatic set_paths(input logic [1:0] a, input logic [1:0] b);
    bus.fwd_path_A = a;
    bus.fwd_path_B = b;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdM"},       32'(bus.rdM), 32'd0);
    check({tag, " rdW"},       32'(bus.rdW), 32'd0);
    check({tag, " rdU"},       32'(bus.rdU), 32'd0);
    check({tag, " RegWriteM"}, 32'(bus.RegWriteM), 32'd0);
    check({tag, " RegWriteW"}, 32'(bus.RegWriteW), 32'd0);
    check({tag, " RegWriteU"}, 32'(bus.RegWriteU), 32'd0);
    check({tag, " resultW"},   bus.resultW, 32'd0);
    check({tag, " operand_A"}, bus.operand_A, 32'd0);
    check({tag, " operand_B"}, bus.operand_B, 32'd0);
    check({tag, " stall"},     32'(bus.load_use_stall), 32'd0);
  endtask

  task automatic check_stages(input string tag, input logic [4:0] rm,
                              input logic [4:0] rw, input logic [4:0] ru,
                              input logic wm, input logic ww, input logic wu);
    check({tag, " rdM"},       32'(bus.rdM), 32'(rm));
    check({tag, " rdW"},       32'(bus.rdW), 32'(rw));
    check({tag, " rdU"},       32'(bus.rdU), 32'(ru));
    check({tag, " RegWriteM"}, 32'(bus.RegWriteM), 32'(wm));
    check({tag, " RegWriteW"}, 32'(bus.RegWriteW), 32'(ww));
    check({tag, " RegWriteU"}, 32'(bus.RegWriteU), 32'(wu));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{32'h0000_000A, 32'h0000_000B, 2'b00, 2'b00, 32'h0000_000A, 32'h0000_000B, 1'b0};
    vecs[1] = '{32'h0000_000A, 32'h0000_000B, 2'b01, 2'b10, 32'h0000_1515, 32'h0000_1414, 1'b0};
    vecs[2] = '{32'h0000_000A, 32'h0000_000B, 2'b10, 2'b11, 32'h0000_1414, 32'h0000_1313, 1'b0};
    vecs[3] = '{32'h0000_000A, 32'h0000_000B, 2'b11, 2'b01, 32'h0000_1313, 32'h0000_1515, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h1234_5678, 2'b00, 2'b11, 32'hFFFF_FFFF, 32'h0000_1313, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h1234_5678, 2'b01, 2'b01, 32'h0000_1515, 32'h0000_1515, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 2'b00, 32'h0000_1313, 32'h0000_0001, 1'b0};

    rst = 1'b1;
    bus.hold_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.mem_rdataW = 32'd0;
    bus.rs1_rf = 32'd0;
    bus.rs2_rf = 32'd0;
    bus.fwd_path_A = 2'b00;
    bus.fwd_path_B = 2'b00;
    set_e(5'd5, 1'b1, 1'b0, 32'h11);

    // Reset held for two edges with a live writer in E.
    tick();
    check_all_zero("reset1");
    tick();
    check_all_zero("reset2");
    rst = 1'b0;
    #1;
    check_all_zero("post_reset");

    // ALU chain: x5 = 0x11 forwarded from M, then W, then U.
    tick();
    set_e(5'd6, 1'b1, 1'b0, 32'h22);
    set_paths(2'b01, 2'b00);
    check("chain rdM", 32'(bus.rdM), 32'd5);
    check("chain M opA", bus.operand_A, 32'h11);
    tick();
    set_e(5'd0, 1'b0, 1'b0, 32'h0);
    set_paths(2'b10, 2'b00);
    check("chain W opA", bus.operand_A, 32'h11);
    check("chain resultW", bus.resultW, 32'h11);
    tick();
    set_paths(2'b11, 2'b00);
    check("chain U opA", bus.operand_A, 32'h11);
    check("chain rdU", 32'(bus.rdU), 32'd5);

    // Load-use: load to x7 reaches M, consumer selects M on B.
    set_e(5'd7, 1'b1, 1'b1, 32'hDEAD);
    set_paths(2'b00, 2'b00);
    tick();
    set_e(5'd8, 1'b1, 1'b0, 32'h33);
    set_paths(2'b00, 2'b01);
    check("lu stall", 32'(bus.load_use_stall), 32'd1);
    tick();
    check("lu bubble RegWriteM", 32'(bus.RegWriteM), 32'd0);
    check("lu bubble rdM", 32'(bus.rdM), 32'd0);
    check("lu rdW", 32'(bus.rdW), 32'd7);
    bus.mem_rdataW = 32'hCAFE;
    set_paths(2'b00, 2'b10);
    check("lu opB", bus.operand_B, 32'hCAFE);
    check("lu stall clear", 32'(bus.load_use_stall), 32'd0);
    check("lu resultW", bus.resultW, 32'hCAFE);
    tick();
    bus.mem_rdataW = 32'd0;
    set_paths(2'b11, 2'b00);
    check("lu U data", bus.operand_A, 32'hCAFE);
    check_stages("lu adv", 5'd8, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);

    // Fill all three stages, then freeze for three edges with a flush inside.
    set_paths(2'b00, 2'b00);
    set_e(5'd10, 1'b1, 1'b0, 32'h44);
    tick();
    set_e(5'd11, 1'b1, 1'b0, 32'h55);
    tick();
    check_stages("pre_hold", 5'd11, 5'd10, 5'd8, 1'b1, 1'b1, 1'b1);
    set_e(5'd12, 1'b1, 1'b0, 32'h66);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.flush_i = (i == 1);
      tick();
      check_stages($sformatf("hold%0d", i), 5'd11, 5'd10, 5'd8, 1'b1, 1'b1, 1'b1);
      check($sformatf("hold%0d resultW", i), bus.resultW, 32'h44);
    end
    bus.hold_i = 1'b0;

    // Flush: E writer to x9 is dropped, W and U still advance.
    set_e(5'd9, 1'b1, 1'b0, 32'h99);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check_stages("flush", 5'd0, 5'd11, 5'd10, 1'b0, 1'b1, 1'b1);
    check("flush resultW", bus.resultW, 32'h55);

    // Build M=0x1515, W=0x1414, U=0x1313 and freeze for the mux table.
    set_e(5'd13, 1'b1, 1'b0, 32'h1313);
    tick();
    set_e(5'd14, 1'b1, 1'b0, 32'h1414);
    tick();
    set_e(5'd15, 1'b1, 1'b0, 32'h1515);
    tick();
    bus.hold_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.rs1_rf = vecs[i].rs1;
      bus.rs2_rf = vecs[i].rs2;
      set_paths(vecs[i].path_a, vecs[i].path_b);
      check($sformatf("vec%0d opA", i), bus.operand_A, vecs[i].exp_a);
      check($sformatf("vec%0d opB", i), bus.operand_B, vecs[i].exp_b);
      check($sformatf("vec%0d stall", i), 32'(bus.load_use_stall), 32'(vecs[i].exp_stall));
      tick();
    end
    bus.hold_i = 1'b0;
    bus.rs1_rf = 32'd0;
    bus.rs2_rf = 32'd0;

    // Stall qualifiers: rd=0 load, non-writing load, then a real one.
    set_paths(2'b00, 2'b00);
    set_e(5'd0, 1'b1, 1'b1, 32'h77);
    tick();
    set_paths(2'b01, 2'b01);
    check("x0 load no stall", 32'(bus.load_use_stall), 32'd0);
    set_e(5'd3, 1'b0, 1'b1, 32'h88);
    tick();
    check("nowrite load no stall", 32'(bus.load_use_stall), 32'd0);
    set_e(5'd3, 1'b1, 1'b1, 32'h99);
    set_paths(2'b00, 2'b00);
    tick();
    set_paths(2'b10, 2'b11);
    check("load path W no stall", 32'(bus.load_use_stall), 32'd0);
    set_paths(2'b01, 2'b00);
    check("load path M stall", 32'(bus.load_use_stall), 32'd1);
    bus.hold_i = 1'b1;
    tick();
    bus.hold_i = 1'b0;
    check("hold beats stall rdM", 32'(bus.rdM), 32'd3);
    check("hold beats stall RegWriteM", 32'(bus.RegWriteM), 32'd1);

    // Mid-operation reset with all three stages valid and a stall pending.
    set_paths(2'b00, 2'b00);
    set_e(5'd20, 1'b1, 1'b0, 32'h1);
    tick();
    set_e(5'd21, 1'b1, 1'b0, 32'h2);
    tick();
    set_e(5'd22, 1'b1, 1'b1, 32'h3);
    tick();
    set_paths(2'b01, 2'b00);
    check_stages("pre_rst", 5'd22, 5'd21, 5'd20, 1'b1, 1'b1, 1'b1);
    check("pre_rst stall", 32'(bus.load_use_stall), 32'd1);
    rst = 1'b1;
    tick();
    check_stages("mid_rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mid_rst stall", 32'(bus.load_use_stall), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
